// File: rtl/rs232_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs232_pkg
// Description : Shared types and helpers for the rs232 transmit arbiter:
//               header tag, FSM state encoding, width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rs232_pkg;

  // Upper nibble of every channel-ID header byte
  localparam logic [3:0] HEADER_TAG = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } arb_state_e;

  // Bits needed to hold a byte count from 0 to max_len inclusive
  function automatic int count_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Bits needed to index n requesters (at least one)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Header byte announcing which requester owns the following packet
  function automatic logic [7:0] header_byte(input logic [3:0] id);
    return {HEADER_TAG, id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin priority encoder. Searches the
//               request vector starting one position after the pointer and
//               wrapping, returning the first hit as one-hot and binary.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import rs232_pkg::*;
#(
  parameter int N    = 4,
  parameter int IDXW = idx_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [IDXW-1:0] cand;

  // Walk candidates ptr+1 .. ptr+N (mod N); the first requesting one wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDXW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rs232_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rs232_tx_arbiter
// Description : Shares one rs232 transmitter byte port among N requesters.
//               Grants whole packets round-robin; a packet ends on a byte
//               flagged last or when MAX_LEN bytes have been sent. Payload
//               bytes pass through combinationally from the owner.
//               Optional macro RS232_ARB_HEADER_EN prepends a {4'hA, id}
//               header byte to every packet.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int N       = 4,
  parameter int MAX_LEN = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int              IDXW      = idx_width(N);
  localparam int              CW        = count_width(MAX_LEN);
  // Pointer starts at N-1 so the search after reset begins at requester 0
  localparam logic [IDXW-1:0] PTR_RESET = IDXW'(N - 1);
  localparam logic [CW:0]     MAX_LEN_W = (CW + 1)'(MAX_LEN);

  arb_state_e      state_q;
  logic [N-1:0]    grant_q;
  logic [IDXW-1:0] gidx_q;
  logic [IDXW-1:0] ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
`ifdef RS232_ARB_HEADER_EN
  logic            hdr_valid_q;
  logic [7:0]      hdr_data_q;
`endif

  logic [N-1:0]    pick_gnt;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  logic [7:0]      sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            payload;
  logic            xfer;
  logic            pkt_end;
  logic [CW:0]     count_inc;

  rr_picker #(
    .N    (N),
    .IDXW (IDXW)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Select the owner's byte, valid and last flag using the one-hot grant
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        sel_data  = req_data[8*i +: 8];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  // Payload transfer detection, packet-end condition and saturating count
  always_comb begin
    payload   = (state_q == ST_PAYLOAD);
    xfer      = payload && sel_valid && tx_ready;
    count_inc = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
    pkt_end   = sel_last || (count_inc == MAX_LEN_W);
    count_d   = (count_q == {CW{1'b1}}) ? count_q : count_inc[CW-1:0];
  end

  // Output steering: owner pass-through in PAYLOAD, registered header otherwise
  always_comb begin
    req_ready = payload ? (grant_q & {N{tx_ready}}) : '0;
`ifdef RS232_ARB_HEADER_EN
    tx_data   = payload ? sel_data  : hdr_data_q;
    tx_valid  = payload ? sel_valid : hdr_valid_q;
`else
    tx_data   = payload ? sel_data  : 8'h00;
    tx_valid  = payload ? sel_valid : 1'b0;
`endif
    grant     = grant_q;
    busy      = (state_q != ST_IDLE);
  end

  // Arbitration FSM: pick in IDLE, optional header, then payload until end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= PTR_RESET;
      count_q     <= '0;
`ifdef RS232_ARB_HEADER_EN
      hdr_valid_q <= 1'b0;
      hdr_data_q  <= 8'h00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_gnt;
            gidx_q  <= pick_idx;
            count_q <= '0;
`ifdef RS232_ARB_HEADER_EN
            state_q     <= ST_HEADER;
            hdr_valid_q <= 1'b1;
            hdr_data_q  <= header_byte(4'(pick_idx));
`else
            state_q     <= ST_PAYLOAD;
`endif
          end
        end
`ifdef RS232_ARB_HEADER_EN
        ST_HEADER: begin
          if (tx_ready) begin
            state_q     <= ST_PAYLOAD;
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= 8'h00;
          end
        end
`endif
        ST_PAYLOAD: begin
          if (xfer) begin
            if (pkt_end) begin
              ptr_q   <= gidx_q;
              grant_q <= '0;
              count_q <= '0;
              state_q <= ST_IDLE;
            end else begin
              count_q <= count_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
